// File: rtl/process_pc_unit_pkg.sv
// Shared definitions for the multi-process program-counter unit.
// Holds the scheduler state encoding, the default slot count and its PID width,
// and the quantum loaded after reset.
package process_pc_unit_pkg;

    localparam int PC_NPROC           = 4;
    localparam int PC_PID_W           = $clog2(PC_NPROC);
    localparam int PC_DEFAULT_QUANTUM = 100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SWITCH = 2'd2
    } pc_state_t;

endpackage

// File: rtl/process_pc_unit_rr_pick.sv
// Round-robin next-valid finder for the process scheduler.
// The search starts at cur_pid+1, wraps around, and checks cur_pid itself last.
// found is low when no slot is valid. next_pid then echoes cur_pid.
module rr_pick #(
    parameter int NPROC = 4,
    parameter int PID_W = $clog2(NPROC)
)(
    input  logic [NPROC-1:0] valid,
    input  logic [PID_W-1:0] cur_pid,
    output logic [PID_W-1:0] next_pid,
    output logic             found
);

    // Walk the slots in round-robin order and keep the first valid one.
    always_comb begin
        logic [PID_W-1:0] idx;
        found    = 1'b0;
        next_pid = cur_pid;
        idx      = cur_pid;
        for (int i = 1; i <= NPROC; i++) begin
            idx = cur_pid + PID_W'(i);
            if (!found && valid[idx]) begin
                found    = 1'b1;
                next_pid = idx;
            end
        end
    end

endmodule

// File: rtl/process_pc_unit.sv
// Multi-process program counter.
// Keeps one saved PC per process slot and drives the fetch address of the
// process that is currently dispatched. A process switch takes one bubble cycle,
// and the Switching output is high during that cycle.
// Optional feature macro: PC_UNIT_PREEMPT_EN. It enables the quantum counter and
// timer preemption. Without it, the unit switches only on Yield or Kill.
module process_pc_unit
    import process_pc_unit_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int NPROC           = PC_NPROC,
    parameter int QUANTUM_W       = 16,
    parameter int DEFAULT_QUANTUM = PC_DEFAULT_QUANTUM
)(
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [ADDR_W-1:0]        NextPC,
    input  logic                     Halt,
    input  logic                     Yield,
    input  logic                     Kill,
    input  logic                     LoadSlot,
    input  logic [$clog2(NPROC)-1:0] PIDIn,
    input  logic [ADDR_W-1:0]        AddrIn,
    input  logic                     SetQuantum,
    input  logic [QUANTUM_W-1:0]     QuantumIn,
    output logic [ADDR_W-1:0]        PC,
    output logic [$clog2(NPROC)-1:0] PID,
    output logic                     Switching,
    output logic                     Idle
);

    localparam int PID_W = $clog2(NPROC);

    pc_state_t         state_q;
    pc_state_t         state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [PID_W-1:0]  pid_q;
    logic [NPROC-1:0]  valid_q;
    logic [ADDR_W-1:0] slot_q [NPROC];

    logic [PID_W-1:0]  pick_pid;
    logic              pick_found;
    logic              expiry;
    logic              run_kill;
    logic              run_save;
    logic              run_adv;
    logic              dispatch;

    rr_pick #(
        .NPROC (NPROC),
        .PID_W (PID_W)
    ) u_rr_pick (
        .valid    (valid_q),
        .cur_pid  (pid_q),
        .next_pid (pick_pid),
        .found    (pick_found)
    );

`ifdef PC_UNIT_PREEMPT_EN
    logic [QUANTUM_W-1:0] quantum_q;
    logic [QUANTUM_W-1:0] counter_q;

    assign expiry = (counter_q == QUANTUM_W'(1)) && !Halt;

    // Latch a new quantum. Zero saturates to one so that a process always gets at least one cycle.
    always_ff @(posedge Clock) begin
        if (Reset)
            quantum_q <= QUANTUM_W'(DEFAULT_QUANTUM);
        else if (SetQuantum)
            quantum_q <= (QuantumIn == '0) ? QUANTUM_W'(1) : QuantumIn;
    end

    // Reload the counter on dispatch and count down only on cycles that actually execute.
    always_ff @(posedge Clock) begin
        if (Reset)
            counter_q <= QUANTUM_W'(DEFAULT_QUANTUM);
        else if (dispatch)
            counter_q <= quantum_q;
        else if (run_adv)
            counter_q <= counter_q - QUANTUM_W'(1);
    end
`else
    logic unused_quantum;

    assign expiry         = 1'b0;
    assign unused_quantum = ^{SetQuantum, QuantumIn};
`endif

    assign run_kill = (state_q == ST_RUN) && Kill;
    assign run_save = (state_q == ST_RUN) && !Kill && (Yield || expiry);
    assign run_adv  = (state_q == ST_RUN) && !Kill && !Yield && !expiry && !Halt;
    assign dispatch = (state_q == ST_SWITCH) && pick_found;

    // Scheduler state register.
    always_ff @(posedge Clock) begin
        if (Reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic: wake on any valid slot, leave RUN on kill/yield/expiry, and pick or idle in SWITCH.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (|valid_q) state_d = ST_SWITCH;
            ST_RUN:    if (run_kill || run_save) state_d = ST_SWITCH;
            ST_SWITCH: state_d = pick_found ? ST_RUN : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        Switching = (state_q == ST_SWITCH);
        Idle      = (state_q == ST_IDLE);
    end

    // Live PC and PID: load both on dispatch, and advance the PC only on an executed cycle.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc_q  <= '0;
            pid_q <= '0;
        end else if (dispatch) begin
            pc_q  <= slot_q[pick_pid];
            pid_q <= pick_pid;
        end else if (run_adv) begin
            pc_q <= NextPC;
        end
    end

    // Slot array and valid bits. LoadSlot comes last, so it overrides a same-cycle save or kill.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            valid_q <= '0;
            for (int i = 0; i < NPROC; i++)
                slot_q[i] <= '0;
        end else begin
            if (run_kill)
                valid_q[pid_q] <= 1'b0;
            if (run_save)
                slot_q[pid_q] <= NextPC;
            if (LoadSlot) begin
                slot_q[PIDIn]  <= AddrIn;
                valid_q[PIDIn] <= 1'b1;
            end
        end
    end

    assign PC  = pc_q;
    assign PID = pid_q;

endmodule

// File: tb/tb_process_pc_unit.sv
// Scoreboard bench for process_pc_unit. Each cycle the stimulus pushes the
// expected PC/PID/Switching/Idle after the coming edge, and the monitor pops
// and compares just after that edge. The scenario follows PC_UNIT_PREEMPT_EN.
module tb_process_pc_unit;

    logic        Clock;
    logic        Reset;
    logic [31:0] NextPC;
    logic        Halt;
    logic        Yield;
    logic        Kill;
    logic        LoadSlot;
    logic [1:0]  PIDIn;
    logic [31:0] AddrIn;
    logic        SetQuantum;
    logic [15:0] QuantumIn;
    logic [31:0] PC;
    logic [1:0]  PID;
    logic        Switching;
    logic        Idle;

    logic        npc_force;
    logic [31:0] npc_val;

    typedef struct {
        int          step;
        logic [31:0] pc;
        logic [1:0]  pid;
        logic        sw;
        logic        idle;
    } exp_t;

    exp_t expQ[$];
    int   stepNo     = 0;
    int   vectors    = 0;
    int   miscompares = 0;

    process_pc_unit dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .NextPC     (NextPC),
        .Halt       (Halt),
        .Yield      (Yield),
        .Kill       (Kill),
        .LoadSlot   (LoadSlot),
        .PIDIn      (PIDIn),
        .AddrIn     (AddrIn),
        .SetQuantum (SetQuantum),
        .QuantumIn  (QuantumIn),
        .PC         (PC),
        .PID        (PID),
        .Switching  (Switching),
        .Idle       (Idle)
    );

    // The datapath normally feeds PC+1. A test can force a branch target instead.
    assign NextPC = npc_force ? npc_val : PC + 32'd1;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic checkOutput(input exp_t e);
        vectors++;
        if (PC !== e.pc || PID !== e.pid || Switching !== e.sw || Idle !== e.idle) begin
            miscompares++;
            $display("[TB] FAIL step %0d: got pc=%h pid=%0d sw=%b idle=%b, want pc=%h pid=%0d sw=%b idle=%b",
                     e.step, PC, PID, Switching, Idle, e.pc, e.pid, e.sw, e.idle);
        end
    endtask

    // Monitor: pop the expectation for each edge and check it 1 ns later.
    always begin
        @(posedge Clock);
        #1;
        if (expQ.size() > 0)
            checkOutput(expQ.pop_front());
    end

    // Push the state expected after the next edge, run the edge, then drop the one-cycle pulses.
    task automatic applyStimulus(input logic [31:0] e_pc, input logic [1:0] e_pid,
                                 input logic e_sw, input logic e_idle);
        exp_t e;
        e.step = stepNo;
        e.pc   = e_pc;
        e.pid  = e_pid;
        e.sw   = e_sw;
        e.idle = e_idle;
        stepNo++;
        expQ.push_back(e);
        @(posedge Clock);
        #2;
        Yield      = 1'b0;
        Kill       = 1'b0;
        LoadSlot   = 1'b0;
        SetQuantum = 1'b0;
        npc_force  = 1'b0;
    endtask

    task automatic expRun(input logic [31:0] p, input logic [1:0] id);
        applyStimulus(p, id, 1'b0, 1'b0);
    endtask

    task automatic expSw(input logic [31:0] p, input logic [1:0] id);
        applyStimulus(p, id, 1'b1, 1'b0);
    endtask

    task automatic expIdle(input logic [31:0] p, input logic [1:0] id);
        applyStimulus(p, id, 1'b0, 1'b1);
    endtask

    task automatic load(input logic [1:0] id, input logic [31:0] a);
        LoadSlot = 1'b1;
        PIDIn    = id;
        AddrIn   = a;
    endtask

    initial begin
        Reset      = 1'b1;
        Halt       = 1'b0;
        Yield      = 1'b0;
        Kill       = 1'b0;
        LoadSlot   = 1'b0;
        PIDIn      = 2'd0;
        AddrIn     = 32'd0;
        SetQuantum = 1'b0;
        QuantumIn  = 16'd0;
        npc_force  = 1'b0;
        npc_val    = 32'd0;

        expIdle(32'h0, 2'd0);
        Reset = 1'b0;
        repeat (20) expIdle(32'h0, 2'd0);

`ifdef PC_UNIT_PREEMPT_EN
        load(2'd1, 32'h100);
        SetQuantum = 1'b1;
        QuantumIn  = 16'd3;
        expIdle(32'h0, 2'd0);
        load(2'd2, 32'h200);
        expSw(32'h0, 2'd0);
        expRun(32'h100, 2'd1);
        expRun(32'h101, 2'd1);
        expRun(32'h102, 2'd1);
        expSw(32'h102, 2'd1);
        expRun(32'h200, 2'd2);
        expRun(32'h201, 2'd2);
        expRun(32'h202, 2'd2);
        expSw(32'h202, 2'd2);
        expRun(32'h103, 2'd1);
        // Halt freezes both the PC and the quantum.
        expRun(32'h104, 2'd1);
        Halt = 1'b1;
        repeat (5) expRun(32'h104, 2'd1);
        Halt = 1'b0;
        expRun(32'h105, 2'd1);
        expSw(32'h105, 2'd1);
        expRun(32'h203, 2'd2);
        // A yield saves the forced branch target.
        npc_force = 1'b1;
        npc_val   = 32'h250;
        Yield     = 1'b1;
        expSw(32'h203, 2'd2);
        expRun(32'h106, 2'd1);
        expRun(32'h107, 2'd1);
        expRun(32'h108, 2'd1);
        expSw(32'h108, 2'd1);
        expRun(32'h250, 2'd2);
        Kill = 1'b1;
        expSw(32'h250, 2'd2);
        expRun(32'h109, 2'd1);
        expRun(32'h10A, 2'd1);
        expRun(32'h10B, 2'd1);
        expSw(32'h10B, 2'd1);
        expRun(32'h10C, 2'd1);
        Kill = 1'b1;
        expSw(32'h10C, 2'd1);
        expIdle(32'h10C, 2'd1);
        expIdle(32'h10C, 2'd1);
        // A quantum of zero saturates to one cycle per dispatch.
        load(2'd3, 32'h300);
        SetQuantum = 1'b1;
        QuantumIn  = 16'd0;
        expIdle(32'h10C, 2'd1);
        expSw(32'h10C, 2'd1);
        expRun(32'h300, 2'd3);
        expSw(32'h300, 2'd3);
        expRun(32'h301, 2'd3);
        expSw(32'h301, 2'd3);
        expRun(32'h302, 2'd3);
`else
        load(2'd1, 32'h100);
        SetQuantum = 1'b1;
        QuantumIn  = 16'd3;
        expIdle(32'h0, 2'd0);
        expSw(32'h0, 2'd0);
        expRun(32'h100, 2'd1);
        // Without preemption the single process keeps running with no switch.
        for (int i = 1; i <= 1000; i++)
            expRun(32'h100 + i, 2'd1);
        Yield = 1'b1;
        expSw(32'h4E8, 2'd1);
        expRun(32'h4E9, 2'd1);
        // Yield is still honoured while Halt is high.
        Halt = 1'b1;
        repeat (3) expRun(32'h4E9, 2'd1);
        Yield = 1'b1;
        expSw(32'h4E9, 2'd1);
        Halt = 1'b0;
        expRun(32'h4EA, 2'd1);
        // A load to the same slot wins over the yield save.
        Yield = 1'b1;
        load(2'd1, 32'h700);
        expSw(32'h4EA, 2'd1);
        expRun(32'h700, 2'd1);
        // A load to the running slot does not touch the live PC.
        load(2'd1, 32'h800);
        expRun(32'h701, 2'd1);
        expRun(32'h702, 2'd1);
        load(2'd2, 32'h200);
        expRun(32'h703, 2'd1);
        // A load wins over a kill of the same PID.
        Kill = 1'b1;
        load(2'd1, 32'h900);
        expSw(32'h703, 2'd1);
        expRun(32'h200, 2'd2);
        Yield = 1'b1;
        expSw(32'h200, 2'd2);
        expRun(32'h900, 2'd1);
        Kill = 1'b1;
        expSw(32'h900, 2'd1);
        expRun(32'h201, 2'd2);
        Kill = 1'b1;
        expSw(32'h201, 2'd2);
        expIdle(32'h201, 2'd2);
        expIdle(32'h201, 2'd2);
`endif

        for (int w = 0; w < 4 && expQ.size() > 0; w++)
            @(posedge Clock);
        #3;
        if (expQ.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL drain: got %0d pending expectations, want 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/process_pc_unit.md
# process_pc_unit

Multi-process program-counter unit that replaces the single-process PC of the processor core. It holds one saved PC per process slot and drives the instruction-fetch address for the currently dispatched process. It switches processes round-robin on a quantum timer expiry, a voluntary yield, or a kill, which lets the BIOS and OS layer run several programs loaded from the simulated HD.

## Interface
- ADDR_W, 32, width of PC and saved-PC slots
- NPROC, 4, number of process slots (power of two, ≥2)
- QUANTUM_W, 16, width of quantum counter
- DEFAULT_QUANTUM, 100, quantum after reset
- Clock  in  1  single clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high
- NextPC  in  ADDR_W  next-PC candidate from datapath (PCSrc mux output)
- Halt  in  1  freeze PC and quantum counter (I/O wait)
- Yield  in  1  current process gives up CPU; resumes at NextPC
- Kill  in  1  current process terminates; slot invalidated
- LoadSlot  in  1  write AddrIn into slot PIDIn and mark it valid
- PIDIn  in  $clog2(NPROC)  slot index for LoadSlot
- AddrIn  in  ADDR_W  start PC for LoadSlot
- SetQuantum  in  1  latch QuantumIn as new quantum
- QuantumIn  in  QUANTUM_W  new quantum value
- PC  out  ADDR_W  fetch address (Endereco)
- PID  out  $clog2(NPROC)  currently dispatched process
- Switching  out  1  high during SWITCH cycle; datapath treats instruction as bubble (no RegWrite/MemWrite/WriteHD)
- Idle  out  1  high in IDLE state

## Operation
- States: IDLE, RUN, SWITCH.
- Reset: PC=0, PID=0, valid[]=0, slots=0, quantum=DEFAULT_QUANTUM, counter=DEFAULT_QUANTUM, state IDLE, Idle=1, Switching=0.
- IDLE: PC held. If any valid bit is set, go to SWITCH next cycle.
- RUN priority (highest first): Kill, Yield, expiry, Halt, normal.
  - Kill: valid[PID]<=0, no save, go to SWITCH.
  - Yield: slot[PID]<=NextPC, go to SWITCH. Yield and Kill are honoured even while Halt is high.
  - Expiry (counter==1 and Halt low): slot[PID]<=NextPC, go to SWITCH.
  - Halt: PC and counter unchanged.
  - Normal: PC<=NextPC, counter-=1.
- SWITCH: round-robin search PID+1, PID+2, … wrapping, ending at PID itself. The first valid slot is dispatched: PID<=slot index, PC<=slot[index], counter<=quantum, go to RUN. If no slot is valid, go to IDLE with PC unchanged.
- LoadSlot works in every state and writes only the slot array. A load to the running PID does not change the live PC; it takes effect at that process's next dispatch.
- LoadSlot in the same cycle as a save to the same slot: LoadSlot wins, and the valid bit is set.
- LoadSlot in the same cycle as a Kill of the same PID: LoadSlot wins, and the slot stays valid with AddrIn.
- SetQuantum: quantum<=QuantumIn, with 0 saturated to 1. It takes effect at the next dispatch, not on the running counter.
- A process runs exactly `quantum` non-halted RUN cycles per dispatch unless it yields or is killed.

## Timing
- PC is registered, so fetch address changes one edge after the event.
- Expiry, Yield, or Kill in cycle n puts SWITCH in cycle n+1 (Switching=1) and the new PC in cycle n+2.
- Switch overhead: exactly one bubble cycle.
- IDLE to first dispatched PC: 2 cycles after valid becomes set (IDLE, then SWITCH).
- Reset asserted in any state returns to reset values on the next edge; in-flight saves are discarded.

## Configuration
- PC_UNIT_PREEMPT_EN defined: quantum counter, SetQuantum/QuantumIn and expiry preemption are present.
- Not defined: cooperative scheduling only. Switches happen solely on Yield or Kill, the counter logic is removed, SetQuantum and QuantumIn are ignored, and ports remain for pin compatibility.

## Structure
- Shared package holds the state enum (IDLE/RUN/SWITCH), the PID width constant derived from NPROC, and DEFAULT_QUANTUM.
- Sub-module rr_pick: combinational round-robin next-valid finder. It takes valid[NPROC] and current PID and outputs next PID and found flag.

## Test plan
- Reset → PC=0, PID=0, Idle=1, Switching=0; stays Idle for 20 cycles with no LoadSlot.
- Dispatch and round-robin: load slot1=0x100 and slot2=0x200, quantum 3, NextPC=PC+1.
  - PC sequence 0x100,0x101,0x102, SWITCH, 0x200,0x201,0x202, SWITCH, 0x103.
  - PID sequence 1,2,1.
- Halt for 5 cycles at PC 0x101 → PC frozen; process still gets 3 executed cycles before SWITCH.
- Yield at PC 0x101 with NextPC=0x102 → SWITCH next cycle; on re-dispatch PID1 resumes at 0x102.
- Kill PID2, then PID1 runs back-to-back dispatches (SWITCH re-selects PID1). Kill PID1 → IDLE, Idle=1, PC unchanged.
- Macro off: single loaded process runs 1000 cycles with no Switching pulse. Yield → one-cycle Switching, same PID re-dispatched.
